// File: rtl/sprite_motion_fsm.sv
`timescale 1ns/1ps
// Player sprite motion/animation controller: move/anim clock-enable ticks drive x/y, facing and sprite-sheet column.
// Define SPRITE_WRAP_EN to make the horizontal screen edges wrap instead of clamp.
module sprite_motion_fsm #(
   parameter int COORD_W     = 10,
   parameter int SPRITE_W    = 50,
   parameter int SCREEN_W    = 640,
   parameter int X_START     = 200,
   parameter int GROUND_Y    = 430,
   parameter int JUMP_H      = 110,
   parameter int MOVE_DIV    = 131072,
   parameter int ANIM_DIV    = 16,
   parameter int WALK_FRAMES = 4,
   parameter int RIGHT_BASE  = 0,
   parameter int LEFT_BASE   = 250,
   parameter int ATK_R       = 200,
   parameter int ATK_L       = 450,
   parameter int HIT_R       = 550,
   parameter int HIT_L       = 500,
   parameter int ATK_TICKS   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               forward,
   input  logic               backward,
   input  logic               jump,
   input  logic               attack,
   input  logic               hit,
   output logic [COORD_W-1:0] x_pos,
   output logic [COORD_W-1:0] y_pos,
   output logic [COORD_W-1:0] sprite_num,
   output logic               facing,
   output logic               attack_active,
   output logic [2:0]         state,
   output logic               move_tick
);

   localparam int DIV_W   = (MOVE_DIV    > 1) ? $clog2(MOVE_DIV)    : 1;
   localparam int ANIM_W  = (ANIM_DIV    > 1) ? $clog2(ANIM_DIV)    : 1;
   localparam int FRAME_W = (WALK_FRAMES > 1) ? $clog2(WALK_FRAMES) : 1;
   localparam int JUMP_W  = (JUMP_H      > 0) ? $clog2(JUMP_H + 1)  : 1;
   localparam int ATK_LEN = ATK_TICKS * ANIM_DIV;
   localparam int ATK_W   = (ATK_LEN     > 1) ? $clog2(ATK_LEN)     : 1;

   localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(MOVE_DIV - 1);
   localparam logic [ANIM_W-1:0]  ANIM_LAST  = ANIM_W'(ANIM_DIV - 1);
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(WALK_FRAMES - 1);
   localparam logic [JUMP_W-1:0]  JUMP_TOP   = JUMP_W'(JUMP_H);
   localparam logic [ATK_W-1:0]   ATK_LAST   = ATK_W'(ATK_LEN - 1);

   localparam logic [COORD_W-1:0] C_ONE    = COORD_W'(1);
   localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(SCREEN_W - SPRITE_W);
   localparam logic [COORD_W-1:0] X_RESET  = COORD_W'(X_START);
   localparam logic [COORD_W-1:0] Y_GROUND = COORD_W'(GROUND_Y);
   localparam logic [COORD_W-1:0] STRIDE   = COORD_W'(SPRITE_W);
   localparam logic [COORD_W-1:0] C_R_BASE = COORD_W'(RIGHT_BASE);
   localparam logic [COORD_W-1:0] C_L_BASE = COORD_W'(LEFT_BASE);
   localparam logic [COORD_W-1:0] C_ATK_R  = COORD_W'(ATK_R);
   localparam logic [COORD_W-1:0] C_ATK_L  = COORD_W'(ATK_L);
   localparam logic [COORD_W-1:0] C_HIT_R  = COORD_W'(HIT_R);
   localparam logic [COORD_W-1:0] C_HIT_L  = COORD_W'(HIT_L);

   // Position taken when a move runs off an edge: wrap to the opposite edge, or hold.
`ifdef SPRITE_WRAP_EN
   localparam logic [COORD_W-1:0] X_FWD_EDGE = '0;
   localparam logic [COORD_W-1:0] X_BWD_EDGE = X_MAX;
`else
   localparam logic [COORD_W-1:0] X_FWD_EDGE = X_MAX;
   localparam logic [COORD_W-1:0] X_BWD_EDGE = '0;
`endif

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WALK      = 3'd1,
      S_JUMP_UP   = 3'd2,
      S_JUMP_DOWN = 3'd3,
      S_ATTACK    = 3'd4,
      S_HIT       = 3'd5
   } state_t;

   state_t               r_state;
   logic [DIV_W-1:0]     r_div;
   logic [ANIM_W-1:0]    r_anim;
   logic [FRAME_W-1:0]   r_idx;
   logic [JUMP_W-1:0]    r_jump_cnt;
   logic [ATK_W-1:0]     r_atk_cnt;
   logic [COORD_W-1:0]   r_x, r_y, r_sprite;
   logic                 r_facing, r_attack;

   state_t               w_next;
   logic                 w_move_tick, w_anim_tick;
   logic                 w_fwd_only, w_bwd_only, w_dir;
   logic                 w_face_nxt;
   logic [FRAME_W-1:0]   w_idx_nxt;
   logic [COORD_W-1:0]   w_x_moved, w_y_up, w_y_dn, w_walk_base, w_sprite_nxt;

   assign w_move_tick = (r_div == DIV_LAST);
   assign w_anim_tick = w_move_tick && (r_anim == ANIM_LAST);
   assign w_fwd_only  = forward & ~backward;
   assign w_bwd_only  = backward & ~forward;
   assign w_dir       = w_fwd_only | w_bwd_only;
   assign w_y_up      = r_y - C_ONE;
   assign w_y_dn      = r_y + C_ONE;

   // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_x_moved  = r_x;
      w_face_nxt = r_facing;
      if (w_fwd_only) begin
         w_face_nxt = 1'b1;
         w_x_moved  = (r_x >= X_MAX) ? X_FWD_EDGE : r_x + C_ONE;
      end else if (w_bwd_only) begin
         w_face_nxt = 1'b0;
         w_x_moved  = (r_x == '0) ? X_BWD_EDGE : r_x - C_ONE;
      end
   end

   // Next state for the coming move tick; priority hit > attack > jump > walk.
   always_comb begin
      w_next = r_state;
      if (hit) begin
         w_next = S_HIT;
      end else begin
         case (r_state)
            S_IDLE, S_WALK: begin
               if (attack)     w_next = S_ATTACK;
               else if (jump)  w_next = S_JUMP_UP;
               else if (w_dir) w_next = S_WALK;
               else            w_next = S_IDLE;
            end
            S_ATTACK: begin
               if (jump)                       w_next = S_JUMP_UP;
               else if (r_atk_cnt == ATK_LAST) w_next = w_dir ? S_WALK : S_IDLE;
            end
            S_JUMP_UP:   if (r_jump_cnt == JUMP_TOP) w_next = S_JUMP_DOWN;
            S_JUMP_DOWN: if (w_y_dn == Y_GROUND)     w_next = w_dir ? S_WALK : S_IDLE;
            S_HIT:       w_next = S_HIT;
            default:     w_next = S_IDLE;
         endcase
      end
   end

   // The walk frame only advances while walking on in the same direction.
   always_comb begin
      w_idx_nxt = '0;
      if (w_next == S_WALK && r_state == S_WALK && w_face_nxt == r_facing) begin
         w_idx_nxt = r_idx;
         if (w_anim_tick) w_idx_nxt = (r_idx == FRAME_LAST) ? '0 : r_idx + FRAME_W'(1);
      end
      w_walk_base = w_face_nxt ? C_R_BASE : C_L_BASE;
      case (w_next)
         S_HIT:    w_sprite_nxt = r_facing ? C_HIT_R : C_HIT_L;
         S_ATTACK: w_sprite_nxt = r_facing ? C_ATK_R : C_ATK_L;
         S_WALK:   w_sprite_nxt = w_walk_base + COORD_W'(w_idx_nxt) * STRIDE;
         default:  w_sprite_nxt = w_walk_base;
      endcase
   end

   // NOTE: all registered state uses non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div      <= '0;
         r_anim     <= '0;
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_jump_cnt <= '0;
         r_atk_cnt  <= '0;
         r_x        <= X_RESET;
         r_y        <= Y_GROUND;
         r_sprite   <= C_R_BASE;
         r_facing   <= 1'b1;
         r_attack   <= 1'b0;
      end else begin
         r_div <= w_move_tick ? '0 : r_div + DIV_W'(1);
         if (w_move_tick) begin
            r_anim    <= (r_anim == ANIM_LAST) ? '0 : r_anim + ANIM_W'(1);
            r_state   <= w_next;
            r_idx     <= w_idx_nxt;
            r_sprite  <= w_sprite_nxt;
            r_attack  <= (w_next == S_ATTACK);
            r_atk_cnt <= (r_state == S_ATTACK && w_next == S_ATTACK) ? r_atk_cnt + ATK_W'(1) : '0;
            if (w_next inside {S_IDLE, S_WALK, S_JUMP_UP, S_JUMP_DOWN}) begin
               r_x      <= w_x_moved;
               r_facing <= w_face_nxt;
            end
            if (w_next == S_JUMP_UP) begin
               r_y        <= w_y_up;
               r_jump_cnt <= (r_state == S_JUMP_UP) ? r_jump_cnt + JUMP_W'(1) : JUMP_W'(1);
            end else if (w_next == S_JUMP_DOWN || (r_state == S_JUMP_DOWN && w_next != S_HIT)) begin
               r_y <= w_y_dn;
            end
         end
      end
   end

   assign x_pos         = r_x;
   assign y_pos         = r_y;
   assign sprite_num    = r_sprite;
   assign facing        = r_facing;
   assign attack_active = r_attack;
   assign state         = r_state;
   assign move_tick     = w_move_tick;

endmodule
